uarc_receiver_arbiter: RTL and testbench



---
 rtl/uarc_receiver_arbiter_if.sv | 52 +++++
 rtl/uarc_receiver_arbiter.sv | 144 ++++++++++++++
 tb/tb_uarc_receiver_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uarc_receiver_arbiter_if.sv
// Bundle of every receiver-bus and core-side message signal around the
// inbound arbiter. clk/reset stay as plain ports on the arbiter.
//   slave  : arbiter side (takes requests/payloads/msg_ready, drives acks/msg_*)
//   master : environment side (receiver buses plus the consuming core)
// Parameters: WORD_MAG (word width = 1<<WORD_MAG), TOTAL_BUSES.
interface uarc_receiver_arbiter_if #(
  parameter int WORD_MAG    = 5,
  parameter int TOTAL_BUSES = 4
);
  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int BUS_W      = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

  logic [TOTAL_BUSES-1:0]                 receiver_enables;
  logic [TOTAL_BUSES-1:0]                 enable_mask;
  logic [TOTAL_BUSES-1:0]                 receiver_kills;
  logic [TOTAL_BUSES-1:0]                 receiver_incepts;
  logic [TOTAL_BUSES-1:0]                 receiver_sends;
  logic [TOTAL_BUSES-1:0]                 receiver_streams;
  logic [TOTAL_BUSES-1:0]                 receiver_kill_acks;
  logic [TOTAL_BUSES-1:0]                 receiver_incept_acks;
  logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
  logic [TOTAL_BUSES-1:0]                 receiver_stream_acks;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_permissions;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_addresses;

  logic                                   msg_valid;
  logic                                   msg_ready;
  logic [1:0]                             msg_kind;
  logic [BUS_W-1:0]                       msg_bus;
  logic [WORD_WIDTH-1:0]                  msg_data;
  logic [WORD_WIDTH-1:0]                  msg_incept_permission;
  logic [WORD_WIDTH-1:0]                  msg_incept_address;

  modport slave (
    input  receiver_enables, enable_mask,
    input  receiver_kills, receiver_incepts, receiver_sends, receiver_streams,
    input  receiver_datas, receiver_incept_permissions, receiver_incept_addresses,
    input  msg_ready,
    output receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks,
    output msg_valid, msg_kind, msg_bus, msg_data, msg_incept_permission, msg_incept_address
  );

  modport master (
    output receiver_enables, enable_mask,
    output receiver_kills, receiver_incepts, receiver_sends, receiver_streams,
    output receiver_datas, receiver_incept_permissions, receiver_incept_addresses,
    output msg_ready,
    input  receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks,
    input  msg_valid, msg_kind, msg_bus, msg_data, msg_incept_permission, msg_incept_address
  );
endinterface

// File: rtl/uarc_receiver_arbiter.sv
// Shares core0's single inbound message path between TOTAL_BUSES UARC
// receiver buses. Each cycle one pending kill/incept/send/stream is chosen
// (round-robin across buses, kill > incept > send > stream within a bus),
// acked combinationally, and held for the core in a registered valid/ready
// stage.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   rx     uarc_receiver_arbiter_if.slave: per-bus enables/mask/requests/
//          payloads in, one-hot acks out, msg_* stage towards the core
// Build option: define UARC_RX_ARB_FIXED_PRI_EN to replace round-robin with
// fixed priority (lowest eligible bus index wins, no rr pointer).
module uarc_receiver_arbiter #(
  parameter int WORD_MAG    = 5,
  parameter int TOTAL_BUSES = 4
) (
  input logic                    clk,
  input logic                    reset,
  uarc_receiver_arbiter_if.slave rx
);
  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int BUS_W      = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

  localparam logic [1:0] KIND_KILL   = 2'd0;
  localparam logic [1:0] KIND_INCEPT = 2'd1;
  localparam logic [1:0] KIND_SEND   = 2'd2;
  localparam logic [1:0] KIND_STREAM = 2'd3;

  logic [TOTAL_BUSES-1:0]       elig;
  logic [TOTAL_BUSES-1:0][1:0]  bus_kind;
  logic                         found;
  logic [BUS_W-1:0]             grant_bus;
  logic [1:0]                   grant_kind;
  logic                         capture;
  logic                         issue;

  logic                         valid_q;
  logic [1:0]                   kind_q;
  logic [BUS_W-1:0]             bus_q;
  logic [WORD_WIDTH-1:0]        data_q;
  logic [WORD_WIDTH-1:0]        perm_q;
  logic [WORD_WIDTH-1:0]        addr_q;

  // Per-bus eligibility and highest pending kind.
  for (genvar g = 0; g < TOTAL_BUSES; g++) begin : g_bus
    assign elig[g] = rx.receiver_enables[g] & rx.enable_mask[g] &
                     (rx.receiver_kills[g] | rx.receiver_incepts[g] |
                      rx.receiver_sends[g] | rx.receiver_streams[g]);
    assign bus_kind[g] = rx.receiver_kills[g]   ? KIND_KILL   :
                         rx.receiver_incepts[g] ? KIND_INCEPT :
                         rx.receiver_sends[g]   ? KIND_SEND   : KIND_STREAM;
  end

`ifdef UARC_RX_ARB_FIXED_PRI_EN
  // Scan high to low so the lowest eligible index is the last to win.
  always_comb begin
    found     = 1'b0;
    grant_bus = '0;
    for (int i = TOTAL_BUSES - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found     = 1'b1;
        grant_bus = BUS_W'(i);
      end
    end
  end
`else
  logic [BUS_W-1:0] rr_ptr;

  // rr_ptr < TOTAL_BUSES and off <= TOTAL_BUSES, so one subtraction wraps.
  function automatic int rr_index(input logic [BUS_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= TOTAL_BUSES) s = s - TOTAL_BUSES;
    return s;
  endfunction

  // Search starts just past the last granted bus; offset TOTAL_BUSES
  // revisits the last winner only if nobody else is eligible.
  always_comb begin
    found     = 1'b0;
    grant_bus = '0;
    for (int off = 1; off <= TOTAL_BUSES; off++) begin
      if (!found && elig[rr_index(rr_ptr, off)]) begin
        found     = 1'b1;
        grant_bus = BUS_W'(rr_index(rr_ptr, off));
      end
    end
  end
`endif

  assign grant_kind = bus_kind[grant_bus];
  assign capture    = found & (~valid_q | rx.msg_ready);
  // Acks are suppressed during reset: the message would be discarded anyway.
  assign issue      = capture & ~reset;

  always_comb begin
    rx.receiver_kill_acks   = '0;
    rx.receiver_incept_acks = '0;
    rx.receiver_send_acks   = '0;
    rx.receiver_stream_acks = '0;
    if (issue) begin
      case (grant_kind)
        KIND_KILL:   rx.receiver_kill_acks[grant_bus]   = 1'b1;
        KIND_INCEPT: rx.receiver_incept_acks[grant_bus] = 1'b1;
        KIND_SEND:   rx.receiver_send_acks[grant_bus]   = 1'b1;
        default:     rx.receiver_stream_acks[grant_bus] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      kind_q  <= '0;
      bus_q   <= '0;
      data_q  <= '0;
      perm_q  <= '0;
      addr_q  <= '0;
`ifndef UARC_RX_ARB_FIXED_PRI_EN
      rr_ptr  <= BUS_W'(TOTAL_BUSES - 1);
`endif
    end else if (capture) begin
      valid_q <= 1'b1;
      kind_q  <= grant_kind;
      bus_q   <= grant_bus;
      // send/stream both have kind[1] set; unused fields load zero.
      data_q  <= grant_kind[1] ? rx.receiver_datas[grant_bus] : '0;
      perm_q  <= (grant_kind == KIND_INCEPT) ? rx.receiver_incept_permissions[grant_bus] : '0;
      addr_q  <= (grant_kind == KIND_INCEPT) ? rx.receiver_incept_addresses[grant_bus] : '0;
`ifndef UARC_RX_ARB_FIXED_PRI_EN
      rr_ptr  <= grant_bus;
`endif
    end else if (valid_q && rx.msg_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rx.msg_valid             = valid_q;
  assign rx.msg_kind              = kind_q;
  assign rx.msg_bus               = bus_q;
  assign rx.msg_data              = data_q;
  assign rx.msg_incept_permission = perm_q;
  assign rx.msg_incept_address    = addr_q;
endmodule

// File: tb/tb_uarc_receiver_arbiter.sv
// Bench for uarc_receiver_arbiter: directed scenarios followed by a random
// phase, every cycle compared against a transaction-level reference model
// (pending-request sets per bus, scan-from-pointer arbitration rule).
module tb_uarc_receiver_arbiter;
  localparam int N  = 4;
  localparam int WM = 5;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uarc_receiver_arbiter_if #(.WORD_MAG(WM), .TOTAL_BUSES(N)) bus ();
  uarc_receiver_arbiter #(.WORD_MAG(WM), .TOTAL_BUSES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit         m_valid;
  int         m_kind, m_bus, m_rr;
  logic [W-1:0] m_data, m_perm, m_addr;

  // Ack vectors observed during the last step.
  logic [N-1:0] seen_kill, seen_incept, seen_send, seen_stream;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pick the winner straight from the rules: first eligible bus scanning
  // from the pointer (or from index 0 for fixed priority), highest kind.
  task automatic model_grant(output bit f, output int b, output int k);
    f = 0; b = 0; k = 0;
    for (int off = 1; off <= N; off++) begin
      int c;
`ifdef UARC_RX_ARB_FIXED_PRI_EN
      c = off - 1;
`else
      c = (m_rr + off) % N;
`endif
      if (!f && bus.receiver_enables[c] && bus.enable_mask[c] &&
          (bus.receiver_kills[c] || bus.receiver_incepts[c] ||
           bus.receiver_sends[c] || bus.receiver_streams[c])) begin
        f = 1; b = c;
        if (bus.receiver_kills[c])        k = 0;
        else if (bus.receiver_incepts[c]) k = 1;
        else if (bus.receiver_sends[c])   k = 2;
        else                              k = 3;
      end
    end
  endtask

  // One clock: called just after a negedge with inputs already set.
  task automatic step(input string tag);
    bit f, cap;
    int b, k;
    logic [N-1:0] ek, ei, es, et;
    #1;
    model_grant(f, b, k);
    cap = f && (!m_valid || bus.msg_ready) && !reset;
    ek = '0; ei = '0; es = '0; et = '0;
    if (cap) begin
      case (k)
        0: ek[b] = 1'b1;
        1: ei[b] = 1'b1;
        2: es[b] = 1'b1;
        default: et[b] = 1'b1;
      endcase
    end
    seen_kill = bus.receiver_kill_acks;   seen_incept = bus.receiver_incept_acks;
    seen_send = bus.receiver_send_acks;   seen_stream = bus.receiver_stream_acks;
    chk({tag, " kill_acks"},   seen_kill,   ek);
    chk({tag, " incept_acks"}, seen_incept, ei);
    chk({tag, " send_acks"},   seen_send,   es);
    chk({tag, " stream_acks"}, seen_stream, et);
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_kind = 0; m_bus = 0; m_data = '0; m_perm = '0; m_addr = '0;
      m_rr = N - 1;
    end else if (cap) begin
      m_valid = 1; m_kind = k; m_bus = b; m_rr = b;
      m_data = (k >= 2) ? bus.receiver_datas[b] : '0;
      m_perm = (k == 1) ? bus.receiver_incept_permissions[b] : '0;
      m_addr = (k == 1) ? bus.receiver_incept_addresses[b] : '0;
      // The sender retires the acked request at this edge.
      case (k)
        0: bus.receiver_kills[b]   = 1'b0;
        1: bus.receiver_incepts[b] = 1'b0;
        2: bus.receiver_sends[b]   = 1'b0;
        default: bus.receiver_streams[b] = 1'b0;
      endcase
    end else if (m_valid && bus.msg_ready) begin
      m_valid = 0;
    end
    chk({tag, " msg_valid"}, bus.msg_valid, m_valid);
    if (m_valid) begin
      chk({tag, " msg_kind"}, bus.msg_kind, m_kind);
      chk({tag, " msg_bus"},  bus.msg_bus,  m_bus);
      chk({tag, " msg_data"}, bus.msg_data, m_data);
      chk({tag, " msg_perm"}, bus.msg_incept_permission, m_perm);
      chk({tag, " msg_addr"}, bus.msg_incept_address, m_addr);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] t3_kinds [3];
    t3_kinds[0] = 2'd0; t3_kinds[1] = 2'd1; t3_kinds[2] = 2'd3;

    reset = 1'b1;
    bus.receiver_enables = '1; bus.enable_mask = '1;
    bus.receiver_kills = '0; bus.receiver_incepts = '0;
    bus.receiver_sends = '0; bus.receiver_streams = '0;
    bus.receiver_datas = '0; bus.receiver_incept_permissions = '0;
    bus.receiver_incept_addresses = '0;
    bus.msg_ready = 1'b1;
    m_valid = 0; m_kind = 0; m_bus = 0; m_rr = N - 1;
    m_data = '0; m_perm = '0; m_addr = '0;

    @(negedge clk);
    step("rst");
    chk("rst valid", bus.msg_valid, 0);
    chk("rst kind",  bus.msg_kind, 0);
    chk("rst bus",   bus.msg_bus, 0);
    chk("rst data",  bus.msg_data, 0);
    reset = 1'b0;

    // 1: single send from bus 0.
    bus.receiver_datas[0] = 32'hDEAD_BEEF;
    bus.receiver_sends[0] = 1'b1;
    step("t1");
    chk("t1 send_ack", seen_send, 4'b0001);
    chk("t1 valid", bus.msg_valid, 1);
    chk("t1 kind",  bus.msg_kind, 2);
    chk("t1 bus",   bus.msg_bus, 0);
    chk("t1 data",  bus.msg_data, 32'hDEAD_BEEF);

    // 2: buses 1..3 keep sends up; pointer sits on bus 0.
    for (int i = 0; i < 6; i++) begin
      bus.receiver_sends = 4'b1110;
      for (int b = 1; b < N; b++) bus.receiver_datas[b] = $urandom;
      step("t2");
`ifdef UARC_RX_ARB_FIXED_PRI_EN
      chk("t2 rr bus", bus.msg_bus, 1);
`else
      chk("t2 rr bus", bus.msg_bus, (i % 3) + 1);
`endif
    end
    bus.receiver_sends = '0;

    // 3: kill + incept + stream together on bus 2.
    bus.receiver_kills[2] = 1'b1; bus.receiver_incepts[2] = 1'b1; bus.receiver_streams[2] = 1'b1;
    bus.receiver_datas[2] = 32'h5555_AAAA;
    bus.receiver_incept_permissions[2] = 32'h0000_00F1;
    bus.receiver_incept_addresses[2]   = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step("t3");
      chk("t3 kind", bus.msg_kind, t3_kinds[i]);
      chk("t3 bus", bus.msg_bus, 2);
      if (i == 1) begin
        chk("t3 perm", bus.msg_incept_permission, 32'h0000_00F1);
        chk("t3 addr", bus.msg_incept_address, 32'h1234_5678);
        chk("t3 incept data", bus.msg_data, 0);
      end
      if (i == 2) chk("t3 stream data", bus.msg_data, 32'h5555_AAAA);
    end
    step("drain3");
    chk("drain3 valid", bus.msg_valid, 0);

    // 4: back-pressure hold.
    bus.msg_ready = 1'b0;
    bus.receiver_datas[0] = 32'hA0A0_0001; bus.receiver_sends[0] = 1'b1;
    step("t4 cap");
    chk("t4 cap data", bus.msg_data, 32'hA0A0_0001);
    bus.receiver_datas[0] = 32'hB0B0_0002; bus.receiver_sends[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("t4 hold");
      chk("t4 hold ack", seen_send, 0);
      chk("t4 hold data", bus.msg_data, 32'hA0A0_0001);
      chk("t4 hold valid", bus.msg_valid, 1);
    end
    bus.msg_ready = 1'b1;
    step("t4 go");
    chk("t4 go ack", seen_send, 4'b0001);
    chk("t4 go data", bus.msg_data, 32'hB0B0_0002);
    step("drain4");

    // 5: masked bus.
    bus.enable_mask = 4'b1011;
    bus.receiver_datas[2] = 32'hC0C0_0003; bus.receiver_sends[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("t5 masked");
      chk("t5 masked ack", seen_send, 0);
      chk("t5 masked valid", bus.msg_valid, 0);
    end
    bus.enable_mask = 4'b1111;
    step("t5 unmask");
    chk("t5 unmask ack", seen_send, 4'b0100);
    chk("t5 unmask data", bus.msg_data, 32'hC0C0_0003);

    // 6: reset while a message is held.
    bus.msg_ready = 1'b0;
    bus.receiver_sends[1] = 1'b1; bus.receiver_datas[1] = 32'hD0D0_0004;
    step("t6 cap");
    chk("t6 held", bus.msg_valid, 1);
    bus.receiver_sends[0] = 1'b1; bus.receiver_sends[3] = 1'b1;
    reset = 1'b1;
    step("t6 rst");
    chk("t6 rst acks", {seen_kill, seen_incept, seen_send, seen_stream}, 0);
    chk("t6 rst valid", bus.msg_valid, 0);
    chk("t6 rst fields", {bus.msg_kind, bus.msg_bus, bus.msg_data, bus.msg_incept_permission}, 0);
    chk("t6 rst addr", bus.msg_incept_address, 0);
    reset = 1'b0; bus.msg_ready = 1'b1;
    step("t6 first");
    chk("t6 first bus", bus.msg_bus, 0);
    bus.receiver_sends = '0;
    step("drain6");

    // Random phase.
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < N; b++) begin
        bus.receiver_enables[b] = ($urandom_range(0, 9) != 0);
        bus.enable_mask[b]      = ($urandom_range(0, 7) != 0);
        if (!bus.receiver_kills[b] && $urandom_range(0, 9) == 0) bus.receiver_kills[b] = 1'b1;
        if (!bus.receiver_incepts[b] && $urandom_range(0, 4) == 0) begin
          bus.receiver_incepts[b] = 1'b1;
          bus.receiver_incept_permissions[b] = $urandom;
          bus.receiver_incept_addresses[b]   = $urandom;
        end
        if (!bus.receiver_sends[b] && $urandom_range(0, 2) == 0) begin
          bus.receiver_sends[b] = 1'b1; bus.receiver_datas[b] = $urandom;
        end
        if (!bus.receiver_streams[b] && $urandom_range(0, 3) == 0) begin
          bus.receiver_streams[b] = 1'b1; bus.receiver_datas[b] = $urandom;
        end
        // Occasionally a sender withdraws before being acked.
        if ($urandom_range(0, 19) == 0) bus.receiver_sends[b] = 1'b0;
      end
      bus.msg_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      step("rnd");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
